fc_stream_engine: RTL and testbench
===================================

# fc_stream_engine

Parametrised fully-connected compute core, successor to the fixed-size FC module behind the FC top-level. It buffers a signed feature vector from AXI-Stream, then streams one bias word plus weight rows per output neuron. It computes LANES-wide MACs per beat, with optional ReLU and running argmax, and emits one 32-bit result per neuron on AXI-Stream. Control (start, sizes, mode) comes from the APB register block; done, argmax and cycle count go back to it.

## Interface
Parameters:
- TDATA_W, 32: AXIS data width; must be a multiple of DATA_W.
- DATA_W, 8: signed feature/weight element width; LANES = TDATA_W/DATA_W.
- ACC_W, 32: accumulator and result width; must be ≤ TDATA_W.
- MAX_IN, 1024: maximum input length in elements; must be a multiple of LANES.
- MAX_OUT, 64: maximum output neuron count.

Ports (one clock; reset is asynchronous and active-high):
- CLK, in, 1: clock.
- RESET, in, 1: asynchronous active-high reset.
- start, in, 1: single-cycle start pulse; honoured only in IDLE.
- in_size, in, clog2(MAX_IN+1): input element count.
- out_size, in, clog2(MAX_OUT+1): output neuron count.
- relu_en, in, 1: clamp negative results to 0.
- busy, out, 1: high outside IDLE.
- done, out, 1: one-cycle pulse at job end.
- err, out, 1: sticky error flag; cleared by the next accepted start.
- max_index, out, clog2(MAX_OUT): argmax of emitted results.
- cycle_count, out, 32: cycles from accepted start to done.
- S_AXIS_TREADY, out, 1: input stream ready.
- S_AXIS_TDATA, in, TDATA_W: input stream data.
- S_AXIS_TLAST, in, 1: input stream last.
- S_AXIS_TVALID, in, 1: input stream valid.
- M_AXIS_TREADY, in, 1: output stream ready.
- M_AXIS_TDATA, out, TDATA_W: result, sign-extended.
- M_AXIS_TKEEP, out, TDATA_W/8: all ones while valid, else 0.
- M_AXIS_TLAST, out, 1: marks the final neuron's result.
- M_AXIS_TVALID, out, 1: output stream valid.
- M_AXIS_TUSER, out, 1: constant 0.

## Operation
- Derived values: BEATS = ceil(in_size/LANES). Lane k of a beat is bits [k*DATA_W +: DATA_W]; lane 0 holds the lowest element index.
- FSM states: IDLE, LOAD_F, BIAS, MAC, OUT, FIN.
- IDLE, start accepted:
  - in_size=0, in_size>MAX_IN, out_size=0 or out_size>MAX_OUT → set err, go to FIN with no stream traffic.
  - Otherwise clear err, the counters and the argmax, then go to LOAD_F.
- LOAD_F: accept BEATS beats into the feature buffer (depth MAX_IN/LANES words), then go to BIAS.
- BIAS: accept one beat; the low ACC_W bits load the accumulator. Go to MAC.
- MAC: each beat adds the sum over lanes of feat×weight to the accumulator.
  - Lanes at element index ≥ in_size contribute 0.
  - Products are 2·DATA_W bits signed.
  - The accumulator wraps two's-complement at ACC_W; no saturation.
  - After BEATS beats, go to OUT.
- OUT: result = relu_en && acc<0 ? 0 : acc.
  - Hold TVALID until TREADY.
  - On the handshake, update the argmax: a strictly greater result replaces it, so ties keep the lowest index.
  - Then go to BIAS if neurons remain, else FIN.
- FIN: pulse done, freeze cycle_count, return to IDLE.
- Input TLAST is required on the final weight beat of the final neuron only. A TLAST on any other beat, or a missing one, sets err; processing continues unchanged.

## Timing
- Reset values:
  - busy, done, err, M_AXIS_TVALID, M_AXIS_TLAST and S_AXIS_TREADY: 0.
  - M_AXIS_TDATA, M_AXIS_TKEEP, max_index and cycle_count: 0.
  - State is IDLE. The feature buffer is not reset.
- S_AXIS_TREADY is high only in LOAD_F, BIAS and MAC; it is registered, and a beat transfers on VALID&&READY.
- After the last MAC beat is accepted, M_AXIS_TVALID rises on the next edge. TDATA, TLAST and TKEEP are stable while VALID && !READY.
- Zero-stall throughput: 1 beat/cycle in, and (1+BEATS+1) cycles per neuron.
- A start pulse while busy is ignored.
- done rises one cycle after the final output handshake (or the error decision). busy falls with done.
- cycle_count increments every cycle while busy; it is read as final when done=1.
- RESET mid-job aborts immediately to the reset values; any partial output is dropped.

## Structure
- Package fc_pkg: the state enum, LANES, and the index width functions.
- Sub-module fc_mac_lanes: combinational, LANES signed multiplies plus adder tree, with a lane valid mask input; output is ACC_W bits.
- Top-level engine holds the FSM, feature buffer (inferred RAM, 1-cycle read), counters and output register. The feature read is prefetched so MAC sustains 1 beat/cycle.

## Test plan
- Basic FC, LANES=4, in_size=4, out_size=2, relu off:
  - Stimulus: features [1,2,3,4]; neuron 0 bias 10, weights [1,1,1,1]; neuron 1 bias −5, weights [−1,0,0,0].
  - Required: outputs 20 then −6; TLAST on the second result; max_index=0; done pulses once.
- Partial beat: in_size=5 with garbage in lanes 1–3 of the final beats → those lanes are ignored; the result matches the 5-element dot product.
- ReLU and ties: relu_en=1 with results −7, 3, 3 → outputs 0, 3, 3; max_index=1.
- Backpressure:
  - Random M_AXIS_TREADY at 30% duty and random S_AXIS_TVALID gaps.
  - Required: identical results, TDATA held stable while stalled, and no beats lost.
- Errors:
  - start with out_size=0 → err=1, done pulses, S_AXIS_TREADY stays 0.
  - Early input TLAST → err=1 and results still produced.
- Reset mid-MAC: assert RESET in the middle of neuron 1 → all outputs return to the reset values. A fresh job then completes correctly.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected stream engine.
// Holds the FSM state enum, the default lane count and width helpers
// used to size ports and counters from the module parameters.
package fc_pkg;

  localparam int unsigned DEF_TDATA_W = 32;
  localparam int unsigned DEF_DATA_W  = 8;
  localparam int unsigned LANES       = DEF_TDATA_W / DEF_DATA_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_F,
    BIAS,
    MAC,
    OUT,
    FIN
  } state_t;

  // Bits needed to index n distinct values (at least 1).
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Elements packed into one stream beat.
  function automatic int unsigned lanes_of(input int unsigned tdata_w, input int unsigned data_w);
    return tdata_w / data_w;
  endfunction

endpackage

// File: rtl/fc_mac_lanes.sv
// Combinational dot-product slice: multiplies each signed feature lane by
// the matching weight lane and sums the enabled products.
// Ports:
//   feat, wgt : packed lanes, lane 0 in the low bits
//   mask      : per-lane enable, disabled lanes contribute 0
//   sum       : ACC_W-bit two's-complement sum of enabled products
module fc_mac_lanes import fc_pkg::*; #(
  parameter int unsigned TDATA_W = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 32
) (
  input  logic [TDATA_W-1:0]        feat,
  input  logic [TDATA_W-1:0]        wgt,
  input  logic [TDATA_W/DATA_W-1:0] mask,
  output logic [ACC_W-1:0]          sum
);

  localparam int unsigned NL = lanes_of(TDATA_W, DATA_W);
  localparam int unsigned PW = 2 * DATA_W;

  logic signed [DATA_W-1:0] fa;
  logic signed [DATA_W-1:0] wb;
  logic signed [PW-1:0]     prod;
  logic [ACC_W-1:0]         total;

  // Full-precision signed products, sign-extended into the accumulator width.
  always_comb begin
    total = '0;
    fa    = '0;
    wb    = '0;
    prod  = '0;
    for (int k = 0; k < NL; k++) begin
      fa   = feat[k*DATA_W +: DATA_W];
      wb   = wgt[k*DATA_W +: DATA_W];
      prod = PW'(fa) * PW'(wb);
      if (mask[k]) total = total + ACC_W'(prod);
    end
  end

  assign sum = total;

endmodule

// File: rtl/fc_stream_engine.sv
// Fully-connected compute core. Buffers a feature vector from the input
// stream, then per neuron takes one bias beat and BEATS weight beats,
// accumulates the lane-wise MACs and emits one result on the output stream.
// Ports:
//   CLK, RESET        : clock, asynchronous active-high reset
//   start/in_size/out_size/relu_en : job control, sampled on accepted start
//   busy/done/err/max_index/cycle_count : job status
//   S_AXIS_*          : feature, bias and weight input stream
//   M_AXIS_*          : result output stream (one word per neuron)
module fc_stream_engine import fc_pkg::*; #(
  parameter int unsigned TDATA_W = 32,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned MAX_IN  = 1024,
  parameter int unsigned MAX_OUT = 64
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          start,
  input  logic [idx_w(MAX_IN+1)-1:0]    in_size,
  input  logic [idx_w(MAX_OUT+1)-1:0]   out_size,
  input  logic                          relu_en,
  output logic                          busy,
  output logic                          done,
  output logic                          err,
  output logic [idx_w(MAX_OUT)-1:0]     max_index,
  output logic [31:0]                   cycle_count,
  output logic                          S_AXIS_TREADY,
  input  logic [TDATA_W-1:0]            S_AXIS_TDATA,
  input  logic                          S_AXIS_TLAST,
  input  logic                          S_AXIS_TVALID,
  input  logic                          M_AXIS_TREADY,
  output logic [TDATA_W-1:0]            M_AXIS_TDATA,
  output logic [TDATA_W/8-1:0]          M_AXIS_TKEEP,
  output logic                          M_AXIS_TLAST,
  output logic                          M_AXIS_TVALID,
  output logic                          M_AXIS_TUSER
);

  localparam int unsigned NL    = lanes_of(TDATA_W, DATA_W);
  localparam int unsigned DEPTH = MAX_IN / NL;
  localparam int unsigned AW    = idx_w(DEPTH);
  localparam int unsigned BW    = idx_w(DEPTH + 1);
  localparam int unsigned IW    = idx_w(MAX_IN + 1);
  localparam int unsigned OW    = idx_w(MAX_OUT + 1);
  localparam int unsigned MW    = idx_w(MAX_OUT);

  state_t state, state_nxt;

  logic [IW-1:0]      in_size_q;
  logic [OW-1:0]      out_size_q;
  logic [OW-1:0]      neuron_cnt;
  logic [BW-1:0]      beats_q;
  logic [BW-1:0]      beat_cnt;
  logic               relu_q;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   max_val;
  logic               s_ready;
  logic               m_valid;
  logic               m_last;
  logic [TDATA_W-1:0] m_data;
  logic [TDATA_W/8-1:0] m_keep;

  logic [TDATA_W-1:0] mem [DEPTH];
  logic [TDATA_W-1:0] feat_q;
  logic [AW-1:0]      rd_addr;

  logic               s_fire, m_fire, last_beat, last_neuron, size_bad, exp_last;
  logic [NL-1:0]      lane_mask;
  logic [ACC_W-1:0]   mac_sum, acc_nxt, result_c;

  assign s_fire      = S_AXIS_TVALID && s_ready;
  assign m_fire      = m_valid && M_AXIS_TREADY;
  assign last_beat   = (beat_cnt == beats_q - BW'(1));
  assign last_neuron = (neuron_cnt == out_size_q - OW'(1));
  assign exp_last    = (state == MAC) && last_beat && last_neuron;
  assign size_bad    = (in_size == '0) || (32'(in_size) > MAX_IN) ||
                       (out_size == '0) || (32'(out_size) > MAX_OUT);

  // Mask off lanes past the end of the input vector on the final beat.
  always_comb begin
    lane_mask = '0;
    for (int k = 0; k < NL; k++)
      lane_mask[k] = (32'(beat_cnt) * NL + 32'(k)) < 32'(in_size_q);
  end

  // Prefetch address: the feature word that the next weight beat will need.
  always_comb begin
    rd_addr = AW'(beat_cnt);
    if (state == MAC && s_fire)
      rd_addr = last_beat ? '0 : AW'(beat_cnt + BW'(1));
  end

  // Feature buffer, 1-cycle read, intentionally not reset.
  always_ff @(posedge CLK) begin
    if (state == LOAD_F && s_fire) mem[AW'(beat_cnt)] <= S_AXIS_TDATA;
    feat_q <= mem[rd_addr];
  end

  fc_mac_lanes #(
    .TDATA_W (TDATA_W),
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W)
  ) u_mac (
    .feat (feat_q),
    .wgt  (S_AXIS_TDATA),
    .mask (lane_mask),
    .sum  (mac_sum)
  );

  assign acc_nxt  = acc + mac_sum;
  assign result_c = (relu_q && acc_nxt[ACC_W-1]) ? '0 : acc_nxt;

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = size_bad ? FIN : LOAD_F;
      LOAD_F:  if (s_fire && last_beat) state_nxt = BIAS;
      BIAS:    if (s_fire) state_nxt = MAC;
      MAC:     if (s_fire && last_beat) state_nxt = OUT;
      OUT:     if (m_fire) state_nxt = last_neuron ? FIN : BIAS;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath, counters and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      max_index   <= '0;
      max_val     <= '0;
      cycle_count <= '0;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_last      <= 1'b0;
      m_data      <= '0;
      m_keep      <= '0;
      in_size_q   <= '0;
      out_size_q  <= '0;
      beats_q     <= '0;
      beat_cnt    <= '0;
      neuron_cnt  <= '0;
      relu_q      <= 1'b0;
      acc         <= '0;
    end else begin
      done    <= (state_nxt == FIN);
      busy    <= state_nxt inside {LOAD_F, BIAS, MAC, OUT};
      s_ready <= state_nxt inside {LOAD_F, BIAS, MAC};
      if (busy) cycle_count <= cycle_count + 32'd1;

      if (state == IDLE && start) begin
        cycle_count <= '0;
        err         <= size_bad;
        if (!size_bad) begin
          in_size_q  <= in_size;
          out_size_q <= out_size;
          relu_q     <= relu_en;
          beats_q    <= BW'((32'(in_size) + NL - 1) / NL);
          beat_cnt   <= '0;
          neuron_cnt <= '0;
          max_index  <= '0;
          max_val    <= '0;
        end
      end

      // TLAST belongs on the final weight beat of the final neuron only.
      if (s_fire && (S_AXIS_TLAST != exp_last)) err <= 1'b1;

      case (state)
        LOAD_F: if (s_fire) beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
        BIAS:   if (s_fire) acc <= S_AXIS_TDATA[ACC_W-1:0];
        MAC: begin
          if (s_fire) begin
            acc      <= acc_nxt;
            beat_cnt <= last_beat ? '0 : beat_cnt + BW'(1);
            if (last_beat) begin
              m_valid <= 1'b1;
              m_data  <= TDATA_W'($signed(result_c));
              m_keep  <= '1;
              m_last  <= last_neuron;
            end
          end
        end
        OUT: begin
          if (m_fire) begin
            m_valid    <= 1'b0;
            m_keep     <= '0;
            m_last     <= 1'b0;
            neuron_cnt <= neuron_cnt + OW'(1);
            // First result seeds the argmax; ties keep the earlier neuron.
            if (neuron_cnt == '0 || $signed(m_data[ACC_W-1:0]) > $signed(max_val)) begin
              max_val   <= m_data[ACC_W-1:0];
              max_index <= MW'(neuron_cnt);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TDATA  = m_data;
  assign M_AXIS_TLAST  = m_last;
  assign M_AXIS_TKEEP  = m_keep;
  assign M_AXIS_TUSER  = 1'b0;

endmodule

// File: tb/tb_fc_stream_engine.sv
// Directed bench for fc_stream_engine with default parameters (4 lanes).
module tb_fc_stream_engine;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        start;
  logic [10:0] in_size;
  logic [6:0]  out_size;
  logic        relu_en;
  logic        busy, done, err;
  logic [5:0]  max_index;
  logic [31:0] cycle_count;
  logic        S_AXIS_TREADY;
  logic [31:0] S_AXIS_TDATA;
  logic        S_AXIS_TLAST;
  logic        S_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b0;
  logic [31:0] M_AXIS_TDATA;
  logic [3:0]  M_AXIS_TKEEP;
  logic        M_AXIS_TLAST;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TUSER;

  fc_stream_engine dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .start         (start),
    .in_size       (in_size),
    .out_size      (out_size),
    .relu_en       (relu_en),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .max_index     (max_index),
    .cycle_count   (cycle_count),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TKEEP  (M_AXIS_TKEEP),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TUSER  (M_AXIS_TUSER)
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int failed = 0;
  int rdy_mode = 0;
  int gap_en = 0;
  int done_cnt = 0;
  int keep_bad = 0;
  int stall_bad = 0;
  int sready_cnt = 0;
  logic [31:0] q_data[$];
  logic        q_last[$];
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  // Output sink: drives TREADY, records handshakes, watches stall stability.
  always @(negedge CLK) begin
    if (RESET) begin
      prev_stall = 1'b0;
      M_AXIS_TREADY = 1'b0;
    end else begin
      M_AXIS_TREADY = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 9) < 3);
      if (prev_stall && !(M_AXIS_TVALID && M_AXIS_TDATA == prev_data && M_AXIS_TLAST == prev_last))
        stall_bad++;
      if (M_AXIS_TKEEP !== (M_AXIS_TVALID ? 4'hF : 4'h0)) keep_bad++;
      if (done) done_cnt++;
      if (S_AXIS_TREADY) sready_cnt++;
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        q_data.push_back(M_AXIS_TDATA);
        q_last.push_back(M_AXIS_TLAST);
      end
      prev_stall = M_AXIS_TVALID && !M_AXIS_TREADY;
      prev_data  = M_AXIS_TDATA;
      prev_last  = M_AXIS_TLAST;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    return {8'(d), 8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_done"},   32'(done), 0);
    check({tag, "_err"},    32'(err), 0);
    check({tag, "_mvalid"}, 32'(M_AXIS_TVALID), 0);
    check({tag, "_mlast"},  32'(M_AXIS_TLAST), 0);
    check({tag, "_sready"}, 32'(S_AXIS_TREADY), 0);
    check({tag, "_mdata"},  M_AXIS_TDATA, 0);
    check({tag, "_mkeep"},  32'(M_AXIS_TKEEP), 0);
    check({tag, "_maxidx"}, 32'(max_index), 0);
    check({tag, "_cycles"}, cycle_count, 0);
    check({tag, "_tuser"},  32'(M_AXIS_TUSER), 0);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic start_job(input int isz, input int osz, input logic relu);
    in_size  = 11'(isz);
    out_size = 7'(osz);
    relu_en  = relu;
    start    = 1'b1;
    @(negedge CLK);
    start    = 1'b0;
  endtask

  // Called at a negedge; one beat, transferred on the following posedge.
  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    if (gap_en != 0 && $urandom_range(0, 2) == 0) begin
      S_AXIS_TVALID = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge CLK);
    end
    S_AXIS_TDATA  = d;
    S_AXIS_TLAST  = l;
    S_AXIS_TVALID = 1'b1;
    while (!S_AXIS_TREADY && t < 300) begin
      @(negedge CLK);
      t++;
    end
    if (t >= 300) check("send_timeout", 32'(t), 0);
    @(negedge CLK);
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (!done && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    check({tag, "_done_seen"}, 32'(done), 1);
  endtask

  task automatic check_results(input string tag, input int n,
                               input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic [31:0] e [3];
    e[0] = e0; e[1] = e1; e[2] = e2;
    check({tag, "_count"}, 32'(q_data.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < q_data.size()) begin
        check($sformatf("%s_res%0d", tag, i), q_data[i], e[i]);
        check($sformatf("%s_last%0d", tag, i), 32'(q_last[i]), 32'(i == n - 1));
      end
    end
  endtask

  task automatic clear_log();
    q_data.delete();
    q_last.delete();
    done_cnt = 0;
    keep_bad = 0;
    stall_bad = 0;
    sready_cnt = 0;
  endtask

  task automatic basic_stream(input logic first_last);
    send(pk(1, 2, 3, 4), first_last);
    send(32'd10, 1'b0);
    send(pk(1, 1, 1, 1), 1'b0);
    send(-32'sd5, 1'b0);
    send(pk(-1, 0, 0, 0), 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; start = 1'b0; in_size = '0; out_size = '0; relu_en = 1'b0;
    S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TLAST = 1'b0;
    repeat (3) @(negedge CLK);
    check_reset_values("reset");
    RESET = 1'b0;
    repeat (2) @(negedge CLK);

    // Basic job: outputs 20 and -6, TLAST on the second, 7 busy cycles.
    clear_log();
    start_job(4, 2, 1'b0);
    basic_stream(1'b0);
    wait_done("basic");
    check("basic_cycles", cycle_count, 7);
    check("basic_busy_low", 32'(busy), 0);
    check("basic_err", 32'(err), 0);
    check("basic_maxidx", 32'(max_index), 0);
    @(negedge CLK);
    check("basic_done_pulse", 32'(done_cnt), 1);
    check("basic_done_low", 32'(done), 0);
    check_results("basic", 2, 32'd20, 32'hFFFF_FFFA, 32'd0);
    check("basic_keep", 32'(keep_bad), 0);

    // Partial final beat: garbage lanes 1-3 ignored, 100 + 58 = 158.
    clear_log();
    start_job(5, 1, 1'b0);
    send(pk(1, 2, 3, 4), 1'b0);
    send(pk(5, 127, -128, 85), 1'b0);
    send(32'd100, 1'b0);
    send(pk(2, -3, 4, 5), 1'b0);
    send(pk(6, 99, 99, 99), 1'b1);
    wait_done("partial");
    check("partial_cycles", cycle_count, 6);
    check("partial_err", 32'(err), 0);
    @(negedge CLK);
    check_results("partial", 1, 32'd158, 32'd0, 32'd0);

    // ReLU and ties: -7,3,3 -> 0,3,3, argmax 1; start while busy is ignored.
    clear_log();
    start_job(4, 3, 1'b1);
    send(pk(1, 1, 1, 1), 1'b0);
    in_size = '0;
    out_size = '0;
    start = 1'b1;
    send(-32'sd7, 1'b0);
    start = 1'b0;
    send(pk(0, 0, 0, 0), 1'b0);
    send(32'd3, 1'b0);
    send(pk(0, 0, 0, 0), 1'b0);
    send(32'd0, 1'b0);
    send(pk(1, 1, 1, 0), 1'b1);
    wait_done("relu");
    check("relu_maxidx", 32'(max_index), 1);
    check("relu_err", 32'(err), 0);
    @(negedge CLK);
    check("relu_done_pulse", 32'(done_cnt), 1);
    check_results("relu", 3, 32'd0, 32'd3, 32'd3);

    // Backpressure with input gaps; third neuron wraps past 0x7FFFFFFF.
    clear_log();
    rdy_mode = 1;
    gap_en = 1;
    start_job(8, 3, 1'b0);
    send(pk(1, -2, 3, -4), 1'b0);
    send(pk(5, -6, 7, -8), 1'b0);
    send(32'd0, 1'b0);
    send(pk(1, 1, 1, 1), 1'b0);
    send(pk(1, 1, 1, 1), 1'b0);
    send(32'd1000, 1'b0);
    send(pk(1, 0, 0, 0), 1'b0);
    send(pk(0, 0, 0, 1), 1'b0);
    send(32'h7FFF_FFFF, 1'b0);
    send(pk(-1, -1, -1, -1), 1'b0);
    send(pk(-1, -1, -1, -1), 1'b1);
    wait_done("bp");
    check("bp_maxidx", 32'(max_index), 1);
    check("bp_err", 32'(err), 0);
    @(negedge CLK);
    rdy_mode = 0;
    gap_en = 0;
    check_results("bp", 3, 32'hFFFF_FFFC, 32'd993, 32'h8000_0003);
    check("bp_stall_stable", 32'(stall_bad), 0);
    check("bp_keep", 32'(keep_bad), 0);
    check("bp_done_pulse", 32'(done_cnt), 1);

    // Bad size: err, done pulse, no input ready, no output.
    clear_log();
    start_job(4, 0, 1'b0);
    wait_done("bad");
    check("bad_err", 32'(err), 1);
    check("bad_busy", 32'(busy), 0);
    repeat (2) @(negedge CLK);
    check("bad_sready", 32'(sready_cnt), 0);
    check("bad_done_pulse", 32'(done_cnt), 1);
    check("bad_outputs", 32'(q_data.size()), 0);

    // Early TLAST: err set, results still produced; accepted start clears err.
    clear_log();
    start_job(4, 2, 1'b0);
    check("early_err_cleared", 32'(err), 0);
    basic_stream(1'b1);
    wait_done("early");
    check("early_err", 32'(err), 1);
    @(negedge CLK);
    check_results("early", 2, 32'd20, 32'hFFFF_FFFA, 32'd0);

    // Reset in the middle of neuron 1, then a fresh job.
    clear_log();
    start_job(8, 2, 1'b0);
    send(pk(1, -2, 3, -4), 1'b0);
    send(pk(5, -6, 7, -8), 1'b0);
    send(32'd0, 1'b0);
    send(pk(1, 1, 1, 1), 1'b0);
    send(pk(1, 1, 1, 1), 1'b0);
    send(32'd1000, 1'b0);
    send(pk(1, 0, 0, 0), 1'b0);
    RESET = 1'b1;
    #1;
    check_reset_values("midrst");
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    clear_log();
    start_job(4, 2, 1'b0);
    basic_stream(1'b0);
    wait_done("after_rst");
    check("after_rst_cycles", cycle_count, 7);
    check("after_rst_err", 32'(err), 0);
    @(negedge CLK);
    check_results("after_rst", 2, 32'd20, 32'hFFFF_FFFA, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
